eff_out_level: RTL and testbench
================================

Name: eff_out_level

Overview:
Master output level stage placed directly downstream of eff_pipe, between the effects chain and the I2S/DAC transmitter. It applies a click-free master volume and mute to both channels of each sample: gain slews one LSB at a time toward its target, and the scaled result is saturated to sample width. It also gives a soft start after reset, with gain ramping up from 0.

Parameters:
RAMP_DIV, 32, number of valid samples per 1-LSB gain step (>=1; 1 means one step per sample)
GAIN_W, 8, gain width in bits (unsigned, Q1.7; 128 = unity, 255 ≈ 1.99x)

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
vol_i  input  GAIN_W  target master gain, Q1.7 unsigned
mute_i  input  1  1 forces the target gain to 0 (ramped, not instant)
data_i  input  sample_t  input sample {lc, rc}, signed DATA_WIDTH each (DATA_WIDTH = 24)
vld_i  input  1  input sample valid, single-cycle strobe
data_o  output  sample_t  scaled, saturated sample
vld_o  output  1  output valid, vld_i delayed 2 cycles
clip_o  output  1  pulses with vld_o when either channel saturated
muted_o  output  1  high while the applied gain is 0 and the target is 0
clip_cnt_o  output  16  saturation event count (optional feature)

Behaviour:
- No backpressure. vld_i may be high every cycle or sparse; every valid sample is accepted.
- target_q is registered every cycle: target_q <= mute_i ? 0 : vol_i.
- Gain engine (g_cur, GAIN_W bits; div_cnt, clog2(RAMP_DIV) bits). Updates happen only on cycles with vld_i=1:
  - If g_cur == target_q: div_cnt <= 0.
  - Else if div_cnt == RAMP_DIV-1: g_cur steps ±1 toward target_q and div_cnt <= 0.
  - Else: div_cnt increments.
- FSM state is updated on the same tick, from the post-update g_cur:
  - MUTED: g_cur == 0 and target_q == 0.
  - STEADY: g_cur == target_q != 0.
  - RAMP_UP: g_cur < target_q.
  - RAMP_DOWN: g_cur > target_q.
  - A target change mid-ramp reverses direction at the next step; div_cnt is not cleared.
  - muted_o = (state == MUTED).
- The gain applied to a sample is the g_cur value present in the cycle vld_i is high, before that tick's update.
- Datapath, 2-cycle latency:
  - S1 registers the products p = x * {1'b0, g_cur}, signed, DATA_WIDTH+GAIN_W+1 bits, for lc and rc independently.
  - S2 registers y = sat(p >>> 7). The shift is arithmetic, so the result floors toward -inf.
  - Saturation limits are +2^(DATA_WIDTH-1)-1 and -2^(DATA_WIDTH-1).
  - clip_o = OR of both channel saturation flags, qualified by the S2 valid.
- S1/S2 registers load only when their valid is set; data_o holds its value between vld_o pulses.
- Reset (asynchronous, also mid-operation):
  - Cleared: data_o = 0, vld_o = 0, clip_o = 0, g_cur = 0, div_cnt = 0, target_q = 0, clip_cnt_o = 0.
  - State = MUTED, muted_o = 1.
  - In-flight samples are dropped.
  - After release with mute_i=0, gain ramps up from 0 (soft start).
- Boundaries:
  - vol_i = 0 with mute_i = 0 behaves identically to mute.
  - g_cur never wraps.
  - A steady gain of 128 is bit-exact passthrough.
  - vld_i held high continuously produces vld_o continuously, 2 cycles later.

Optional Feature:
EFF_OUT_CLIP_CNT_EN:
- Defined: clip_cnt_o is a 16-bit counter that increments on each clip_o pulse and saturates at 0xFFFF. It clears only on rst.
- Undefined: no counter is built and clip_cnt_o is tied to 0. The port list is unchanged.

Decomposition:
- sample_pkg gains: GAIN_W = 8, GAIN_UNITY = 8'd128, GAIN_FRAC = 7, typedef gain_t (logic [GAIN_W-1:0]), and an enum lvl_state_t {MUTED, STEADY, RAMP_UP, RAMP_DOWN}.
- The gain engine is a natural sub-module: eff_gain_ramp. It holds target_q, div_cnt, g_cur and the FSM, and outputs g_cur and state.
- The top module holds the 2-stage scale/saturate datapath and the optional counter.

Test Plan:
- Soft start, unity passthrough: RAMP_DIV=1, rst, vol_i=128, mute_i=0, lc=rc=1000 every cycle.
  - Output lc rises monotonically over 128 samples to exactly 1000, then holds.
  - vld_o equals vld_i delayed by 2 cycles.
  - muted_o falls after the first sample.
- Scaling and rounding: steady g=64.
  - lc=-1000 gives -500.
  - lc=-1 gives -1.
  - lc=3 gives 1.
  - rc=7 gives 3.
- Saturation: steady g=255.
  - lc=8388607 gives 8388607, clip_o=1.
  - rc=-8388608 gives -8388608, clip_o=1.
  - lc=1000 gives 1992, clip_o=0.
  - With EFF_OUT_CLIP_CNT_EN defined, clip_cnt_o=2 after these samples.
- Mute ramp and reversal: RAMP_DIV=4, steady g=128.
  - mute_i=1: g_cur decrements once every 4 samples.
  - Release mute_i after 40 samples: state goes RAMP_DOWN→RAMP_UP with g_cur=118 at the turn.
  - A full mute reaches MUTED with data_o=0 after 512 samples.
- Sparse valid and reset mid-ramp: vld_i every 5th cycle.
  - Gain steps only on valid cycles.
  - Asserting rst between S1 and S2 produces no vld_o, and g_cur=0 immediately.
  - data_o=0 until a new sample completes.

Source files
------------

// File: rtl/sample_pkg.sv
// rtl/sample_pkg.sv - sample, gain and level-state types shared by the output level stage
package sample_pkg;
  localparam int DATA_WIDTH = 24;
  localparam int GAIN_W     = 8;
  localparam int GAIN_FRAC  = 7;
  localparam int PROD_W     = DATA_WIDTH + GAIN_W + 1;

  typedef logic [GAIN_W-1:0] gain_t;
  localparam gain_t GAIN_UNITY = 8'd128;

  typedef struct packed {
    logic signed [DATA_WIDTH-1:0] lc;
    logic signed [DATA_WIDTH-1:0] rc;
  } sample_t;

  typedef enum logic [1:0] {MUTED, STEADY, RAMP_UP, RAMP_DOWN} lvl_state_t;

  localparam logic signed [PROD_W-1:0] Y_MAX = PROD_W'((2 ** (DATA_WIDTH - 1)) - 1);
  localparam logic signed [PROD_W-1:0] Y_MIN = PROD_W'(-(2 ** (DATA_WIDTH - 1)));

  // Returns {saturated, y}; the arithmetic shift floors toward -inf.
  function automatic logic [DATA_WIDTH:0] sat_shift(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] s;
    s = p >>> GAIN_FRAC;
    if (s > Y_MAX) begin
      sat_shift = {1'b1, Y_MAX[DATA_WIDTH-1:0]};
    end else if (s < Y_MIN) begin
      sat_shift = {1'b1, Y_MIN[DATA_WIDTH-1:0]};
    end else begin
      sat_shift = {1'b0, s[DATA_WIDTH-1:0]};
    end
  endfunction
endpackage

// File: rtl/eff_gain_ramp.sv
// rtl/eff_gain_ramp.sv - click-free gain slew engine with level FSM
module eff_gain_ramp
  import sample_pkg::*;
#(
  parameter int RAMP_DIV = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  gain_t      vol_i,
  input  logic       mute_i,
  input  logic       vld_i,
  output gain_t      g_cur_o,
  output lvl_state_t state_o
);
  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  gain_t            target_q, target_d;
  gain_t            g_cur_q, g_cur_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  lvl_state_t       state_q, state_d;

  always_comb begin
    target_d  = mute_i ? '0 : vol_i;
    g_cur_d   = g_cur_q;
    div_cnt_d = div_cnt_q;
    state_d   = state_q;
    if (vld_i) begin
      if (g_cur_q == target_q) begin
        div_cnt_d = '0;
      end else if (div_cnt_q == CNT_LAST) begin
        div_cnt_d = '0;
        g_cur_d   = (g_cur_q < target_q) ? g_cur_q + gain_t'(1) : g_cur_q - gain_t'(1);
      end else begin
        div_cnt_d = div_cnt_q + CNT_W'(1);
      end
      // State reflects the gain after this tick's step.
      if (g_cur_d == target_q) begin
        state_d = (target_q == '0) ? MUTED : STEADY;
      end else if (g_cur_d < target_q) begin
        state_d = RAMP_UP;
      end else begin
        state_d = RAMP_DOWN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target_q  <= '0;
      g_cur_q   <= '0;
      div_cnt_q <= '0;
      state_q   <= MUTED;
    end else begin
      target_q  <= target_d;
      g_cur_q   <= g_cur_d;
      div_cnt_q <= div_cnt_d;
      state_q   <= state_d;
    end
  end

  assign g_cur_o = g_cur_q;
  assign state_o = state_q;
endmodule

// File: rtl/eff_out_level.sv
// rtl/eff_out_level.sv - master volume/mute stage: 2-cycle scale and saturate
// Optional saturation counter under EFF_OUT_CLIP_CNT_EN.
module eff_out_level
  import sample_pkg::*;
#(
  parameter int RAMP_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  gain_t       vol_i,
  input  logic        mute_i,
  input  sample_t     data_i,
  input  logic        vld_i,
  output sample_t     data_o,
  output logic        vld_o,
  output logic        clip_o,
  output logic        muted_o,
  output logic [15:0] clip_cnt_o
);
  gain_t      g_cur;
  lvl_state_t state;

  eff_gain_ramp #(.RAMP_DIV(RAMP_DIV)) u_ramp (
    .clk     (clk),
    .rst     (rst),
    .vol_i   (vol_i),
    .mute_i  (mute_i),
    .vld_i   (vld_i),
    .g_cur_o (g_cur),
    .state_o (state)
  );

  logic signed [PROD_W-1:0]     p_lc_q, p_lc_d, p_rc_q, p_rc_d;
  logic                         s1_vld_q, s1_vld_d;
  logic signed [DATA_WIDTH-1:0] y_lc, y_rc;
  logic                         sat_lc, sat_rc;
  sample_t                      data_q, data_d;
  logic                         vld_q, vld_d, clip_q, clip_d;

  assign {sat_lc, y_lc} = sat_shift(p_lc_q);
  assign {sat_rc, y_rc} = sat_shift(p_rc_q);

  always_comb begin
    p_lc_d   = p_lc_q;
    p_rc_d   = p_rc_q;
    s1_vld_d = vld_i;
    // Gain is zero-extended so the product stays signed.
    if (vld_i) begin
      p_lc_d = PROD_W'($signed(data_i.lc)) * PROD_W'($signed({1'b0, g_cur}));
      p_rc_d = PROD_W'($signed(data_i.rc)) * PROD_W'($signed({1'b0, g_cur}));
    end
    data_d = data_q;
    vld_d  = s1_vld_q;
    clip_d = s1_vld_q & (sat_lc | sat_rc);
    if (s1_vld_q) begin
      data_d.lc = y_lc;
      data_d.rc = y_rc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_lc_q   <= '0;
      p_rc_q   <= '0;
      s1_vld_q <= 1'b0;
      data_q   <= '0;
      vld_q    <= 1'b0;
      clip_q   <= 1'b0;
    end else begin
      p_lc_q   <= p_lc_d;
      p_rc_q   <= p_rc_d;
      s1_vld_q <= s1_vld_d;
      data_q   <= data_d;
      vld_q    <= vld_d;
      clip_q   <= clip_d;
    end
  end

`ifdef EFF_OUT_CLIP_CNT_EN
  logic [15:0] clip_cnt_q, clip_cnt_d;

  always_comb begin
    clip_cnt_d = clip_cnt_q;
    if (clip_d && clip_cnt_q != 16'hFFFF) begin
      clip_cnt_d = clip_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clip_cnt_q <= '0;
    end else begin
      clip_cnt_q <= clip_cnt_d;
    end
  end

  assign clip_cnt_o = clip_cnt_q;
`else
  assign clip_cnt_o = '0;
`endif

  assign data_o  = data_q;
  assign vld_o   = vld_q;
  assign clip_o  = clip_q;
  assign muted_o = (state == MUTED);
endmodule

// File: tb/tb_eff_out_level.sv
// tb/tb_eff_out_level.sv - table vectors, hand sequences and random stimulus vs a reference model
module tb_eff_out_level;
  import sample_pkg::*;

  localparam int RAMP_DIV = 4;

  logic        clk;
  logic        rst;
  gain_t       vol_i;
  logic        mute_i;
  sample_t     data_i;
  logic        vld_i;
  sample_t     data_o;
  logic        vld_o;
  logic        clip_o;
  logic        muted_o;
  logic [15:0] clip_cnt_o;

  eff_out_level #(.RAMP_DIV(RAMP_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .vol_i      (vol_i),
    .mute_i     (mute_i),
    .data_i     (data_i),
    .vld_i      (vld_i),
    .data_o     (data_o),
    .vld_o      (vld_o),
    .clip_o     (clip_o),
    .muted_o    (muted_o),
    .clip_cnt_o (clip_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  // Reference model: gain as an integer walking toward the target, outputs as a 2-deep pipe.
  int     m_tgt, m_g, m_div, m_cnt;
  bit     m_muted, m_v1, m_c1, m_vo, m_co;
  longint m_y1l, m_y1r, m_ol, m_or;

  function automatic longint scale(input longint x, input longint g, output bit c);
    longint p, q;
    p = x * g;
    q = p / 128;
    if (p < 0 && q * 128 != p) q -= 1;
    c = 1'b0;
    if (q > 8388607) begin
      q = 8388607;
      c = 1'b1;
    end else if (q < -8388608) begin
      q = -8388608;
      c = 1'b1;
    end
    return q;
  endfunction

  task automatic model_reset();
    m_tgt = 0; m_g = 0; m_div = 0; m_cnt = 0;
    m_muted = 1; m_v1 = 0; m_c1 = 0; m_vo = 0; m_co = 0;
    m_y1l = 0; m_y1r = 0; m_ol = 0; m_or = 0;
  endtask

  task automatic model_tick(input int vol, input bit mute, input bit vld, input int lc, input int rc);
    bit cl, cr;
    m_vo = m_v1;
    m_co = m_v1 && m_c1;
    if (m_v1) begin
      m_ol = m_y1l;
      m_or = m_y1r;
    end
    if (m_co && m_cnt < 65535) m_cnt++;
    m_v1 = vld;
    if (vld) begin
      m_y1l = scale(lc, m_g, cl);
      m_y1r = scale(rc, m_g, cr);
      m_c1  = cl | cr;
      if (m_g == m_tgt) m_div = 0;
      else if (m_div == RAMP_DIV - 1) begin
        m_g  += (m_g < m_tgt) ? 1 : -1;
        m_div = 0;
      end else m_div++;
      m_muted = (m_g == 0 && m_tgt == 0);
    end
    m_tgt = mute ? 0 : vol;
  endtask

  task automatic compare();
    chk("vld_o", vld_o, m_vo);
    chk("clip_o", clip_o, m_co);
    chk("muted_o", muted_o, m_muted);
    chk("data_lc", longint'(data_o.lc), m_ol);
    chk("data_rc", longint'(data_o.rc), m_or);
`ifdef EFF_OUT_CLIP_CNT_EN
    chk("clip_cnt", clip_cnt_o, m_cnt);
`else
    chk("clip_cnt", clip_cnt_o, 0);
`endif
  endtask

  task automatic step(input int vol, input bit mute, input bit vld, input int lc, input int rc);
    vol_i     = gain_t'(vol);
    mute_i    = mute;
    vld_i     = vld;
    data_i.lc = 24'(lc);
    data_i.rc = 24'(rc);
    @(posedge clk);
    model_tick(vol, mute, vld, lc, rc);
    #1;
    compare();
  endtask

  task automatic ramp_to(input int vol);
    for (int i = 0; i < 3000 && m_g != vol; i++) step(vol, 0, 1, 1000, -1000);
    step(vol, 0, 0, 0, 0);
    step(vol, 0, 0, 0, 0);
  endtask

  typedef struct {
    int vol;
    int lc;
    int rc;
    int exp_lc;
    int exp_rc;
    bit exp_clip;
  } vec_t;

  vec_t tbl[7];

  function automatic int rnd24();
    int r;
    r = $urandom;
    r = (r <<< 8) >>> 8;
    return r;
  endfunction

  int prev_lc, non_mono, clips_seen;
  int vol_r;
  bit mute_r;

  initial begin
    tbl[0] = '{128, 12345, -8388608, 12345, -8388608, 1'b0};
    tbl[1] = '{64, -1000, 7, -500, 3, 1'b0};
    tbl[2] = '{64, -1, 0, -1, 0, 1'b0};
    tbl[3] = '{64, 3, -7, 1, -4, 1'b0};
    tbl[4] = '{255, 8388607, 0, 8388607, 0, 1'b1};
    tbl[5] = '{255, 0, -8388608, 0, -8388608, 1'b1};
    tbl[6] = '{255, 1000, 1000, 1992, 1992, 1'b0};

    rst = 1'b1; vol_i = '0; mute_i = 1'b0; vld_i = 1'b0; data_i = '0;
    model_reset();
    #2;
    chk("rst_data_o", data_o, 0);
    chk("rst_vld_o", vld_o, 0);
    chk("rst_clip_o", clip_o, 0);
    chk("rst_muted_o", muted_o, 1);
    chk("rst_clip_cnt", clip_cnt_o, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Soft start toward unity.
    step(128, 0, 0, 0, 0);
    step(128, 0, 1, 1000, 1000);
    chk("soft_muted_falls", muted_o, 0);
    prev_lc = 0; non_mono = 0;
    for (int i = 0; i < 128 * RAMP_DIV + 8; i++) begin
      step(128, 0, 1, 1000, 1000);
      if (vld_o) begin
        if (data_o.lc < prev_lc) non_mono++;
        prev_lc = data_o.lc;
      end
    end
    chk("soft_monotonic", non_mono, 0);
    chk("soft_final_lc", longint'(data_o.lc), 1000);

    // Steady-gain vectors.
    clips_seen = 0;
    foreach (tbl[i]) begin
      if (m_g != tbl[i].vol) ramp_to(tbl[i].vol);
      step(tbl[i].vol, 0, 1, tbl[i].lc, tbl[i].rc);
      step(tbl[i].vol, 0, 0, 0, 0);
      chk($sformatf("tbl%0d_vld", i), vld_o, 1);
      chk($sformatf("tbl%0d_lc", i), longint'(data_o.lc), tbl[i].exp_lc);
      chk($sformatf("tbl%0d_rc", i), longint'(data_o.rc), tbl[i].exp_rc);
      chk($sformatf("tbl%0d_clip", i), clip_o, tbl[i].exp_clip);
      if (tbl[i].exp_clip) clips_seen++;
      step(tbl[i].vol, 0, 0, 0, 0);
    end
`ifdef EFF_OUT_CLIP_CNT_EN
    chk("tbl_clip_cnt", clip_cnt_o, clips_seen);
`else
    chk("tbl_clip_cnt", clip_cnt_o, 0);
`endif

    // Mute ramp with reversal at 118.
    ramp_to(128);
    step(128, 1, 0, 0, 0);
    for (int i = 0; i < 40; i++) step(128, 1, 1, 1000, 1000);
    step(128, 0, 1, 1000, 1000);
    step(128, 0, 0, 0, 0);
    chk("turn_gain_out", longint'(data_o.lc), 921);
    for (int i = 0; i < 600; i++) step(128, 1, 1, 1000, 1000);
    step(128, 1, 0, 0, 0);
    step(128, 1, 0, 0, 0);
    chk("full_mute_muted", muted_o, 1);
    chk("full_mute_data", longint'(data_o.lc), 0);

    // Sparse valid, then reset with a sample in flight.
    for (int i = 0; i < 200; i++) step(128, 0, (i % 5) == 0, 500, -500);
    step(128, 0, 1, 1000, 1000);
    #1 rst = 1'b1;
    #1;
    chk("midrst_vld_o", vld_o, 0);
    chk("midrst_data_o", data_o, 0);
    chk("midrst_muted_o", muted_o, 1);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(128, 0, 0, 0, 0);
      chk("postrst_vld_o", vld_o, 0);
      chk("postrst_data_o", data_o, 0);
    end

    // Random traffic.
    vol_r = 128; mute_r = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) vol_r = $urandom_range(0, 255);
      if ($urandom_range(0, 299) == 0) mute_r = ~mute_r;
      step(vol_r, mute_r, $urandom_range(0, 3) != 0, rnd24(), rnd24());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
